rom_arbiter: RTL and testbench

- Shares one synchronous block ROM between the GB and NES sound cores. The two ports are a GB port with an 18-bit address and a NES port with a 17-bit address. The NES address is offset into the upper region of the ROM.
- Each requester uses a req/ack handshake. Grants are round-robin, and a fixed ROM read latency is sequenced internally.
- Sits between MainBoth's address/data ROM ports and a single ROM instance. This replaces the separate GB and NES ROM instances.

---
 rtl/rom_arbiter_pkg.sv | 21 ++
 rtl/rom_arbiter_if.sv | 32 +++
 rtl/rom_arbiter_rr_arb2.sv | 34 +++
 rtl/rom_arbiter.sv | 105 ++++++++++
 tb/tb_rom_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the GB/NES block-ROM arbiter.
// State and owner encodings are fixed so waveforms match the sound-core docs.
package rom_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef enum logic {
      OWN_GB  = 1'b0,
      OWN_NES = 1'b1
   } owner_e;

   localparam int          GB_ADDR_W        = 18;
   localparam int          NES_ADDR_W       = 17;
   localparam int          CNT_W            = 3;
   localparam logic [17:0] NES_BASE_DEFAULT = 18'h20000;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester and ROM-side signals of the arbiter, bundled into one bus.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface rom_arbiter_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 24
);
   import rom_arbiter_pkg::*;

   logic                  gb_req;
   logic [GB_ADDR_W-1:0]  gb_addr;
   logic                  gb_ack;
   logic [DATA_W-1:0]     gb_data;
   logic                  nes_req;
   logic [NES_ADDR_W-1:0] nes_addr;
   logic                  nes_ack;
   logic [DATA_W-1:0]     nes_data;
   logic [ADDR_W-1:0]     rom_addr;
   logic [DATA_W-1:0]     rom_data;
   logic                  busy;
   logic                  owner;

   modport slave (
      input  gb_req, gb_addr, nes_req, nes_addr, rom_data,
      output gb_ack, gb_data, nes_ack, nes_data, rom_addr, busy, owner
   );

   modport master (
      output gb_req, gb_addr, nes_req, nes_addr, rom_data,
      input  gb_ack, gb_data, nes_ack, nes_data, rom_addr, busy, owner
   );

endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-requester round-robin picker. The pointer names the side that wins a tie
// and moves to the losing side whenever update_i strobes a grant.
module rr_arb2
   import rom_arbiter_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   gb_req_i,
   input  logic   nes_req_i,
   input  logic   update_i,
   output owner_e grant_o,
   output logic   valid_o
);

   owner_e ptr_q;

   // NOTE: every variable gets a default first so no latch can be inferred.
   always_comb begin
      valid_o = gb_req_i | nes_req_i;
      grant_o = OWN_GB;
      if (gb_req_i && nes_req_i) grant_o = ptr_q;
      else if (nes_req_i)        grant_o = OWN_NES;
   end

   // NOTE: state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= OWN_GB;
      end else if (update_i) begin
         ptr_q <= (grant_o == OWN_GB) ? OWN_NES : OWN_GB;
      end
   end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous block ROM between the GB and NES sound cores with a
// round-robin req/ack handshake and an internally sequenced read latency.
module rom_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter int                ADDR_W   = 18,
   parameter int                DATA_W   = 24,
   parameter int                ROM_LAT  = 2,
   parameter logic [ADDR_W-1:0] NES_BASE = ADDR_W'(NES_BASE_DEFAULT)
) (
   input  logic         clk,
   input  logic         rst_n,
   rom_arbiter_if.slave bus
);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   owner_e             owner_q;
   logic [ADDR_W-1:0]  rom_addr_q;
   logic [DATA_W-1:0]  gb_data_q;
   logic [DATA_W-1:0]  nes_data_q;
   logic               gb_ack_q;
   logic               nes_ack_q;
   logic               busy_q;

   owner_e             arb_grant;
   logic               arb_valid;
   logic               grant_stb;
   logic [ADDR_W-1:0]  nes_rom_addr;

   assign grant_stb = (state_q == ST_IDLE) && arb_valid;

   // NES lives in the upper ROM region; overflow past ADDR_W wraps on purpose.
   assign nes_rom_addr = NES_BASE + ADDR_W'(bus.nes_addr);

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .gb_req_i  (bus.gb_req),
      .nes_req_i (bus.nes_req),
      .update_i  (grant_stb),
      .grant_o   (arb_grant),
      .valid_o   (arb_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         owner_q    <= OWN_GB;
         rom_addr_q <= '0;
         gb_data_q  <= '0;
         nes_data_q <= '0;
         gb_ack_q   <= 1'b0;
         nes_ack_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         gb_ack_q  <= 1'b0;
         nes_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  owner_q    <= arb_grant;
                  rom_addr_q <= (arb_grant == OWN_GB) ? ADDR_W'(bus.gb_addr) : nes_rom_addr;
                  cnt_q      <= CNT_W'(ROM_LAT);
                  busy_q     <= 1'b1;
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  // Only the owner's data register is written; the other holds.
                  if (owner_q == OWN_NES) begin
                     nes_data_q <= bus.rom_data;
                     nes_ack_q  <= 1'b1;
                  end else begin
                     gb_data_q  <= bus.rom_data;
                     gb_ack_q   <= 1'b1;
                  end
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RESP: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rom_addr = rom_addr_q;
   assign bus.gb_data  = gb_data_q;
   assign bus.nes_data = nes_data_q;
   assign bus.gb_ack   = gb_ack_q;
   assign bus.nes_ack  = nes_ack_q;
   assign bus.busy     = busy_q;
   assign bus.owner    = owner_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: latency, arbitration order, handshake corner
// cases, asynchronous reset and NES address wrap, against a 2-cycle ROM model.
module tb_rom_arbiter;
   import rom_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   overlap_seen = 1'b0;

   always #5 clk = ~clk;

   rom_arbiter_if #(.ADDR_W(18), .DATA_W(24)) bus  ();
   rom_arbiter_if #(.ADDR_W(18), .DATA_W(24)) bus2 ();

   rom_arbiter #(.ADDR_W(18), .DATA_W(24), .ROM_LAT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   rom_arbiter #(.ADDR_W(18), .DATA_W(24), .ROM_LAT(2), .NES_BASE(18'h3FFFF)) dut_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   function automatic logic [23:0] rom_fn(input logic [17:0] a);
      return {a[5:0], a} ^ 24'h5A5A5A;
   endfunction

   // ROM model: address registered in, data out two cycles later.
   logic [23:0] rom_s1;
   always @(posedge clk) begin
      rom_s1       <= rom_fn(bus.rom_addr);
      bus.rom_data <= rom_s1;
   end

   always @(negedge clk) if (bus.gb_ack && bus.nes_ack) overlap_seen = 1'b1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},     32'(bus.busy),     32'h0);
      check({tag, "_owner"},    32'(bus.owner),    32'h0);
      check({tag, "_gb_ack"},   32'(bus.gb_ack),   32'h0);
      check({tag, "_nes_ack"},  32'(bus.nes_ack),  32'h0);
      check({tag, "_gb_data"},  32'(bus.gb_data),  32'h0);
      check({tag, "_nes_data"}, 32'(bus.nes_data), 32'h0);
      check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'h0);
   endtask

   initial begin
      int acks;
      int ack_who[6];
      int ack_cyc[6];
      int cyc;
      logic [23:0] cap;

      rst_n         = 1'b0;
      bus.gb_req    = 1'b0;
      bus.gb_addr   = '0;
      bus.nes_req   = 1'b0;
      bus.nes_addr  = '0;
      bus2.gb_req   = 1'b0;
      bus2.gb_addr  = '0;
      bus2.nes_req  = 1'b0;
      bus2.nes_addr = '0;
      bus2.rom_data = '0;
      repeat (2) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // GB single read: grant at end of cycle N, ack in N+4.
      bus.gb_addr = 18'h00123;
      bus.gb_req  = 1'b1;
      tick();
      check("t1_rom_addr", 32'(bus.rom_addr), 32'h00123);
      check("t1_busy",     32'(bus.busy),     32'h1);
      bus.gb_req = 1'b0;
      tick();
      tick();
      check("t1_early_ack", 32'(bus.gb_ack), 32'h0);
      tick();
      check("t1_gb_ack",   32'(bus.gb_ack),   32'h1);
      check("t1_nes_ack",  32'(bus.nes_ack),  32'h0);
      check("t1_gb_data",  32'(bus.gb_data),  32'hD65B79);
      tick();
      check("t1_busy_low", 32'(bus.busy),     32'h0);
      check("t1_ack_pulse", 32'(bus.gb_ack),  32'h0);

      // NES single read lands in the upper region.
      bus.nes_addr = 17'h00010;
      bus.nes_req  = 1'b1;
      tick();
      check("t2_rom_addr", 32'(bus.rom_addr), 32'h20010);
      check("t2_owner",    32'(bus.owner),    32'h1);
      bus.nes_req = 1'b0;
      cyc  = 0;
      acks = 0;
      while (!bus.nes_ack && cyc < 10) begin
         tick();
         cyc++;
         if (bus.gb_ack) acks++;
      end
      check("t2_latency",  32'(cyc),          32'd3);
      check("t2_nes_ack",  32'(bus.nes_ack),  32'h1);
      check("t2_gb_acks",  32'(acks),         32'h0);
      check("t2_nes_data", 32'(bus.nes_data), 32'h185A4A);
      check("t2_gb_data",  32'(bus.gb_data),  32'hD65B79);

      // Continuous contention: strict GB/NES alternation, 5-cycle spacing.
      bus.gb_req  = 1'b1;
      bus.nes_req = 1'b1;
      acks = 0;
      for (int i = 0; i < 60 && acks < 6; i++) begin
         tick();
         if (bus.gb_ack || bus.nes_ack) begin
            ack_who[acks] = bus.nes_ack ? 1 : 0;
            ack_cyc[acks] = i;
            cap = bus.nes_ack ? bus.nes_data : bus.gb_data;
            check($sformatf("t3_data%0d", acks), 32'(cap),
                  bus.nes_ack ? 32'h185A4A : 32'hD65B79);
            acks++;
         end
      end
      bus.gb_req  = 1'b0;
      bus.nes_req = 1'b0;
      check("t3_ack_count", 32'(acks), 32'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < acks) begin
            check($sformatf("t3_order%0d", k), 32'(ack_who[k]), 32'(k % 2));
            if (k > 0)
               check($sformatf("t3_spacing%0d", k), 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd5);
         end
      end
      check("t3_overlap", 32'(overlap_seen), 32'h0);
      tick();
      tick();
      check("t3_idle", 32'(bus.busy), 32'h0);

      // Requester drops req and changes addr after the grant.
      bus.gb_addr = 18'h00456;
      bus.gb_req  = 1'b1;
      tick();
      check("t4_rom_addr", 32'(bus.rom_addr), 32'h00456);
      bus.gb_req  = 1'b0;
      bus.gb_addr = 18'h00789;
      acks = 0;
      cap  = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.gb_ack) begin
            acks++;
            cap = bus.gb_data;
         end
      end
      check("t4_ack_count", 32'(acks),         32'd1);
      check("t4_data",      32'(cap),          32'h025E0C);
      check("t4_no_regrant", 32'(bus.rom_addr), 32'h00456);
      check("t4_busy",      32'(bus.busy),     32'h0);

      // Reset asserted while waiting on the ROM.
      bus.gb_addr = 18'h00123;
      bus.gb_req  = 1'b1;
      tick();
      bus.gb_req = 1'b0;
      tick();
      check("t5_in_wait", 32'(bus.busy), 32'h1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("t5_wait_rst");
      tick();
      rst_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.gb_ack || bus.nes_ack) acks++;
      end
      check("t5_no_ack", 32'(acks),     32'd0);
      check("t5_busy",   32'(bus.busy), 32'h0);

      // Reset asserted while an ack is high drops it immediately.
      bus.nes_addr = 17'h00010;
      bus.nes_req  = 1'b1;
      tick();
      bus.nes_req = 1'b0;
      repeat (3) tick();
      check("t5b_ack_high", 32'(bus.nes_ack), 32'h1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("t5b_resp_rst");
      tick();
      rst_n = 1'b1;
      tick();

      // NES offset wraps past the top of the address space.
      bus2.nes_addr = 17'h00002;
      bus2.nes_req  = 1'b1;
      tick();
      check("t6_wrap_addr", 32'(bus2.rom_addr), 32'h00001);
      check("t6_owner",     32'(bus2.owner),    32'h1);
      bus2.nes_req = 1'b0;
      repeat (6) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
